// File: rtl/accelerator_matrix_transpose_pkg.sv
// Shared accelerator definitions: transpose FSM encoding, control/data
// constants and a small index-width helper.
package accelerator_matrix_transpose_pkg;

  typedef enum logic [1:0] {
    STARTER = 2'd0,
    INPUT   = 2'd1,
    OUTPUT  = 2'd2,
    ENDER   = 2'd3
  } state_t;

  localparam logic [63:0] ZERO_CONTROL = 64'd0;
  localparam logic [63:0] ONE_CONTROL  = 64'd1;
  localparam logic [63:0] ZERO_DATA    = 64'd0;

  // Address width needed to index n entries (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/accelerator_matrix_transpose.sv
// Streaming matrix transpose: accepts a SIZE_I x SIZE_J matrix row-major,
// buffers it, then emits the transpose row-major with no stalls.
// The i/j index pair addresses buf[i][j] in both phases: during INPUT j is
// the fast index; during OUTPUT i (the output column) is the fast index, so
// the read address buf[i][j] is exactly the transposed element.
module accelerator_matrix_transpose
  import accelerator_matrix_transpose_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int MAX_I        = 4,
  parameter int MAX_J        = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic                 DATA_IN_I_ENABLE,
  input  logic                 DATA_IN_J_ENABLE,
  output logic                 DATA_OUT_I_ENABLE,
  output logic                 DATA_OUT_J_ENABLE,
  input  logic [DATA_SIZE-1:0] SIZE_I_IN,
  input  logic [DATA_SIZE-1:0] SIZE_J_IN,
  input  logic [DATA_SIZE-1:0] DATA_IN,
  output logic [DATA_SIZE-1:0] DATA_OUT
);

  localparam int I_AW = idx_width(MAX_I);
  localparam int J_AW = idx_width(MAX_J);

  typedef logic [CONTROL_SIZE-1:0] ctrl_t;
  typedef logic [DATA_SIZE-1:0]    data_t;

  localparam ctrl_t CZERO = ctrl_t'(ZERO_CONTROL);
  localparam ctrl_t CONE  = ctrl_t'(ONE_CONTROL);
  localparam data_t DZERO = data_t'(ZERO_DATA);
  localparam ctrl_t CMAX_I = ctrl_t'(MAX_I);
  localparam ctrl_t CMAX_J = ctrl_t'(MAX_J);

  state_t state_q, state_d;
  ctrl_t  size_i_q, size_i_d;
  ctrl_t  size_j_q, size_j_d;
  ctrl_t  i_q, i_d;
  ctrl_t  j_q, j_d;
  data_t  data_out_q, data_out_d;

  data_t  buf_q [MAX_I][MAX_J];
  logic   wr_en;
  data_t  rd_data;
  ctrl_t  size_i_in;
  ctrl_t  size_j_in;
  logic   sizes_ok;

  logic [I_AW-1:0] i_idx;
  logic [J_AW-1:0] j_idx;

  // Sizes are truncated to control width before range checking.
  assign size_i_in = ctrl_t'(SIZE_I_IN);
  assign size_j_in = ctrl_t'(SIZE_J_IN);
  assign sizes_ok  = (size_i_in != CZERO) && (size_i_in <= CMAX_I) &&
                     (size_j_in != CZERO) && (size_j_in <= CMAX_J);

  // Indices are always < size <= MAX, so the low bits address the array.
  assign i_idx   = i_q[I_AW-1:0];
  assign j_idx   = j_q[J_AW-1:0];
  assign rd_data = buf_q[i_idx][j_idx];

  // Next-state, index sequencing and buffer write enable.
  always_comb begin
    state_d    = state_q;
    size_i_d   = size_i_q;
    size_j_d   = size_j_q;
    i_d        = i_q;
    j_d        = j_q;
    data_out_d = data_out_q;
    wr_en      = 1'b0;
    case (state_q)
      STARTER: begin
        if (START) begin
          size_i_d = size_i_in;
          size_j_d = size_j_in;
          i_d      = CZERO;
          j_d      = CZERO;
          state_d  = sizes_ok ? INPUT : ENDER;
        end
      end
      INPUT: begin
        if (DATA_IN_I_ENABLE || DATA_IN_J_ENABLE) begin
          wr_en = 1'b1;
          if (j_q == size_j_q - CONE) begin
            j_d = CZERO;
            if (i_q == size_i_q - CONE) begin
              i_d     = CZERO;
              state_d = OUTPUT;
            end else begin
              i_d = i_q + CONE;
            end
          end else begin
            j_d = j_q + CONE;
          end
        end
      end
      OUTPUT: begin
        data_out_d = rd_data;
        if (i_q == size_i_q - CONE) begin
          i_d = CZERO;
          if (j_q == size_j_q - CONE) begin
            j_d     = CZERO;
            state_d = ENDER;
          end else begin
            j_d = j_q + CONE;
          end
        end else begin
          i_d = i_q + CONE;
        end
      end
      ENDER: begin
        state_d = STARTER;
      end
      default: begin
        state_d = STARTER;
      end
    endcase
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= STARTER;
      size_i_q   <= CZERO;
      size_j_q   <= CZERO;
      i_q        <= CZERO;
      j_q        <= CZERO;
      data_out_q <= DZERO;
    end else begin
      state_q    <= state_d;
      size_i_q   <= size_i_d;
      size_j_q   <= size_j_d;
      i_q        <= i_d;
      j_q        <= j_d;
      data_out_q <= data_out_d;
    end
  end

  // Element buffer; never reset, only read back after being rewritten.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      buf_q[i_idx][j_idx] <= DATA_IN;
    end
  end

  // Output element is read straight from the buffer so the first one lands
  // in the cycle right after the last input; otherwise the last value holds.
  assign DATA_OUT          = (state_q == OUTPUT) ? rd_data : data_out_q;
  assign DATA_OUT_J_ENABLE = (state_q == OUTPUT);
  assign DATA_OUT_I_ENABLE = (state_q == OUTPUT) && (i_q == CZERO);
  assign READY             = (state_q == ENDER);

endmodule
